instr_sequencer: RTL and testbench
==================================

# instr_sequencer

Multi-cycle control sequencer for the CPU's 10-bit instruction path. Fetches instructions from instruction memory over a request/acknowledge handshake, holds the instruction register that drives the field decoder, and steps each instruction through decode, execute, memory and write-back states. It asserts the datapath strobes (ALU, register-file write, data-memory read/write) and owns the program counter. It sits between instruction memory, the decoder and the datapath.

## Interface
- No parameters; PC is fixed at 8 bits, instruction at 10 bits.
- Clock  in  1  rising-edge system clock
- ResetN  in  1  reset, synchronous, active-low
- Run  in  1  allows new fetches; sampled only in FETCH
- InstrReq  out  1  instruction-fetch request
- InstrAddr  out  8  fetch address (= PC)
- InstrAck  in  1  fetch acknowledge; InstrData valid in the same cycle
- InstrData  in  10  fetched instruction
- Instruction  out  10  instruction register, feeds the decoder
- Zero  in  1  ALU zero flag, sampled in EXEC for BEQ
- AluEn  out  1  ALU operate strobe
- MemRead  out  1  data-memory read request
- MemWrite  out  1  data-memory write request
- MemAck  in  1  data-memory acknowledge
- RegWrite  out  1  register-file write strobe
- WbSel  out  2  write-back source: 0 ALU, 1 memory, 2 immediate
- Halted  out  1  core stopped
- Illegal  out  1  sticky illegal-opcode flag
- RetiredCount  out  16  retired instructions; present only with the macro below

## Operation
- States: FETCH, DECODE, EXEC, MEM, WB, HALT. Opcode = Instruction[9:6]; Imm = Instruction[5:0].
- FETCH: if Run=0, InstrReq=0 and stay. If Run=1, InstrReq=1 with InstrAddr=PC, held until InstrAck. Once raised, the request is never withdrawn, even if Run falls. On ack, Instruction<=InstrData and go to DECODE.
- DECODE: one cycle, no strobes.
  - Opcode 0xE: Illegal<=1, go to HALT.
  - Opcode 0xF: go to HALT.
  - Opcode 0xD (NOP): PC<=PC+1, go to FETCH.
  - Any other opcode: go to EXEC.
- EXEC: AluEn=1 for exactly one cycle.
  - 0x0-0x7 (ALU): go to WB with WbSel=0.
  - 0x8 (LOAD): go to MEM.
  - 0x9 (STORE): go to MEM.
  - 0xA (BEQ): PC<=PC+sext(Imm) if Zero=1, else PC+1; go to FETCH.
  - 0xB (JUMP): PC<={PC[7:6],Imm}; go to FETCH.
  - 0xC (LI): go to WB with WbSel=2.
- MEM: LOAD holds MemRead=1 until MemAck, then goes to WB with WbSel=1. STORE holds MemWrite=1 until MemAck, then PC<=PC+1 and goes to FETCH.
- WB: RegWrite=1 for one cycle, PC<=PC+1, go to FETCH. WbSel is stable from EXEC through WB and is 0 otherwise.
- HALT: Halted=1. Only reset exits this state; Run is ignored.
- PC arithmetic is 8-bit modulo 256. PC+1 at 0xFF gives 0x00. The branch offset is signed 6-bit (-32..+31) and wraps the same way.
- MemRead and MemWrite are never high together. At most one of AluEn, MemRead, MemWrite, RegWrite is high in any cycle.

## Timing
- Reset values:
  - State FETCH; PC=0; Instruction=0.
  - InstrReq, AluEn, MemRead, MemWrite, RegWrite, Halted, Illegal all 0; WbSel=0.
  - RetiredCount=0.
- ResetN=0 at any edge, including mid-handshake, forces reset values at that edge. Pending InstrAck or MemAck is ignored and the handshake is abandoned.
- Earliest InstrReq after reset release: first cycle with ResetN=1 and Run=1.
- Cycles per instruction with zero-wait acks:
  - ALU and LI: 4.
  - LOAD: 5.
  - STORE: 4.
  - BEQ and JUMP: 3.
  - NOP: 2.
- Each cycle of InstrAck or MemAck delay adds one cycle.
- Ack inputs arriving while no request is outstanding are ignored.
- All outputs are registered; no combinational path from inputs to outputs.

## Configuration
- INSTR_SEQ_RETIRE_CNT_EN defined:
  - RetiredCount exists.
  - It increments by 1 on entry to FETCH from WB, MEM (STORE), EXEC (BEQ/JUMP) or DECODE (NOP), and wraps at 0xFFFF.
  - HALT and illegal opcodes do not count.
- INSTR_SEQ_RETIRE_CNT_EN undefined: the port and counter are absent; all other behaviour is identical.

## Test plan
- Reset, Run=1, memory returns 0x045 (ALU op 1) with immediate acks -> InstrReq at PC 0, AluEn one cycle later than DECODE, RegWrite with WbSel=0 in cycle 4, next InstrAddr=1.
- LOAD 0x203 with MemAck delayed 3 cycles -> MemRead high 4 cycles, then RegWrite with WbSel=1; MemWrite never high; next InstrAddr=PC+1.
- BEQ at PC 0x05 with Imm=0x3E (-2): Zero=1 -> next InstrAddr=0x03. Zero=0 -> 0x06. BEQ at PC 0x01 with Imm=0x3C (-4) and Zero=1 -> 0xFD.
- Opcode 0xE fetched -> Illegal=1 and Halted=1 two cycles after ack. Both stay high with Run toggling until ResetN=0, then both are 0.
- ResetN pulsed low while MemRead is pending -> MemRead=0 and PC=0 at the next edge; a late MemAck causes no RegWrite.
- With INSTR_SEQ_RETIRE_CNT_EN: run NOP, ALU, STORE, HALT -> RetiredCount=3 and holds.

Source files
------------

// File: rtl/instr_sequencer.sv
// Multi-cycle control sequencer for the 10-bit instruction path: fetch handshake, IR, PC and datapath strobes.
// Optional INSTR_SEQ_RETIRE_CNT_EN adds the 16-bit RetiredCount output.
module instr_sequencer (
    input  logic        Clock,
    input  logic        ResetN,
    input  logic        Run,
    output logic        InstrReq,
    output logic [7:0]  InstrAddr,
    input  logic        InstrAck,
    input  logic [9:0]  InstrData,
    output logic [9:0]  Instruction,
    input  logic        Zero,
    output logic        AluEn,
    output logic        MemRead,
    output logic        MemWrite,
    input  logic        MemAck,
    output logic        RegWrite,
    output logic [1:0]  WbSel,
    output logic        Halted,
    output logic        Illegal
`ifdef INSTR_SEQ_RETIRE_CNT_EN
    ,
    output logic [15:0] RetiredCount
`endif
);

    typedef enum logic [2:0] {
        S_FETCH,
        S_DECODE,
        S_EXEC,
        S_MEM,
        S_WB,
        S_HALT
    } state_t;

    localparam logic [3:0] OP_LOAD    = 4'h8;
    localparam logic [3:0] OP_STORE   = 4'h9;
    localparam logic [3:0] OP_BEQ     = 4'hA;
    localparam logic [3:0] OP_JUMP    = 4'hB;
    localparam logic [3:0] OP_LI      = 4'hC;
    localparam logic [3:0] OP_NOP     = 4'hD;
    localparam logic [3:0] OP_ILLEGAL = 4'hE;
    localparam logic [3:0] OP_HALT    = 4'hF;

    localparam logic [1:0] WB_ALU = 2'd0;
    localparam logic [1:0] WB_MEM = 2'd1;
    localparam logic [1:0] WB_IMM = 2'd2;

    state_t      state, next_state;
    logic [7:0]  pc, pc_next;
    logic [3:0]  opcode;
    logic [5:0]  imm;
    logic [7:0]  pc_inc;
    logic [7:0]  branch_target;
    logic        ir_load;
    logic        set_illegal;

    logic        instr_req_d;
    logic        alu_en_d;
    logic        mem_read_d;
    logic        mem_write_d;
    logic        reg_write_d;
    logic [1:0]  wb_sel_d;
    logic        halted_d;

    assign opcode        = Instruction[9:6];
    assign imm           = Instruction[5:0];
    assign pc_inc        = pc + 8'd1;
    assign branch_target = pc + {{2{imm[5]}}, imm};
    assign InstrAddr     = pc;

    // NOTE: every variable driven here gets a default first, so no path can leave it unassigned and infer a latch.
    always_comb begin
        next_state  = state;
        pc_next     = pc;
        ir_load     = 1'b0;
        set_illegal = 1'b0;
        unique case (state)
            S_FETCH: begin
                // Only an acknowledged outstanding request moves us on; stray acks are ignored.
                if (InstrReq && InstrAck) begin
                    ir_load    = 1'b1;
                    next_state = S_DECODE;
                end
            end
            S_DECODE: begin
                case (opcode)
                    OP_ILLEGAL: begin
                        set_illegal = 1'b1;
                        next_state  = S_HALT;
                    end
                    OP_HALT: next_state = S_HALT;
                    OP_NOP: begin
                        pc_next    = pc_inc;
                        next_state = S_FETCH;
                    end
                    default: next_state = S_EXEC;
                endcase
            end
            S_EXEC: begin
                case (opcode)
                    OP_LOAD, OP_STORE: next_state = S_MEM;
                    OP_BEQ: begin
                        pc_next    = Zero ? branch_target : pc_inc;
                        next_state = S_FETCH;
                    end
                    OP_JUMP: begin
                        pc_next    = {pc[7:6], imm};
                        next_state = S_FETCH;
                    end
                    default: next_state = S_WB;
                endcase
            end
            S_MEM: begin
                if (MemAck) begin
                    if (opcode == OP_STORE) begin
                        pc_next    = pc_inc;
                        next_state = S_FETCH;
                    end else begin
                        next_state = S_WB;
                    end
                end
            end
            S_WB: begin
                pc_next    = pc_inc;
                next_state = S_FETCH;
            end
            S_HALT: next_state = S_HALT;
            default: next_state = S_FETCH;
        endcase
    end

    // Outputs are decoded from the next state and registered, so they line up with the state they describe.
    always_comb begin
        instr_req_d = (next_state == S_FETCH) && (Run || (state == S_FETCH && InstrReq));
        alu_en_d    = (next_state == S_EXEC);
        mem_read_d  = (next_state == S_MEM) && (opcode == OP_LOAD);
        mem_write_d = (next_state == S_MEM) && (opcode == OP_STORE);
        reg_write_d = (next_state == S_WB);
        halted_d    = (next_state == S_HALT);
        wb_sel_d    = WB_ALU;
        if (next_state == S_EXEC || next_state == S_MEM || next_state == S_WB) begin
            if (opcode == OP_LI)
                wb_sel_d = WB_IMM;
            else if (opcode == OP_LOAD)
                wb_sel_d = WB_MEM;
        end
    end

    // NOTE: state is updated with non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge Clock) begin
        if (!ResetN) begin
            state       <= S_FETCH;
            pc          <= 8'd0;
            Instruction <= 10'd0;
            InstrReq    <= 1'b0;
            AluEn       <= 1'b0;
            MemRead     <= 1'b0;
            MemWrite    <= 1'b0;
            RegWrite    <= 1'b0;
            WbSel       <= WB_ALU;
            Halted      <= 1'b0;
            Illegal     <= 1'b0;
        end else begin
            state    <= next_state;
            pc       <= pc_next;
            InstrReq <= instr_req_d;
            AluEn    <= alu_en_d;
            MemRead  <= mem_read_d;
            MemWrite <= mem_write_d;
            RegWrite <= reg_write_d;
            WbSel    <= wb_sel_d;
            Halted   <= halted_d;
            if (ir_load)
                Instruction <= InstrData;
            if (set_illegal)
                Illegal <= 1'b1;
        end
    end

`ifdef INSTR_SEQ_RETIRE_CNT_EN
    // Any return to FETCH from another state retires exactly one instruction.
    always_ff @(posedge Clock) begin
        if (!ResetN)
            RetiredCount <= 16'd0;
        else if (next_state == S_FETCH && state != S_FETCH)
            RetiredCount <= RetiredCount + 16'd1;
    end
`endif

endmodule

// File: tb/tb_instr_sequencer.sv
// Directed self-checking bench for instr_sequencer; RetiredCount checks only when INSTR_SEQ_RETIRE_CNT_EN is defined.
module tb_instr_sequencer;

    logic        Clock = 1'b0;
    logic        ResetN;
    logic        Run;
    logic        InstrReq;
    logic [7:0]  InstrAddr;
    logic        InstrAck;
    logic [9:0]  InstrData;
    logic [9:0]  Instruction;
    logic        Zero;
    logic        AluEn;
    logic        MemRead;
    logic        MemWrite;
    logic        MemAck;
    logic        RegWrite;
    logic [1:0]  WbSel;
    logic        Halted;
    logic        Illegal;
`ifdef INSTR_SEQ_RETIRE_CNT_EN
    logic [15:0] RetiredCount;
`endif

    int tests = 0;
    int fails = 0;

    instr_sequencer dut (
        .Clock       (Clock),
        .ResetN      (ResetN),
        .Run         (Run),
        .InstrReq    (InstrReq),
        .InstrAddr   (InstrAddr),
        .InstrAck    (InstrAck),
        .InstrData   (InstrData),
        .Instruction (Instruction),
        .Zero        (Zero),
        .AluEn       (AluEn),
        .MemRead     (MemRead),
        .MemWrite    (MemWrite),
        .MemAck      (MemAck),
        .RegWrite    (RegWrite),
        .WbSel       (WbSel),
        .Halted      (Halted),
        .Illegal     (Illegal)
`ifdef INSTR_SEQ_RETIRE_CNT_EN
        ,
        .RetiredCount(RetiredCount)
`endif
    );

    always #5 Clock = ~Clock;

    task automatic tick();
        @(posedge Clock);
        #1;
    endtask

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Strobe exclusivity is checked every cycle out of reset.
    always @(negedge Clock) begin
        if (ResetN === 1'b1) begin
            tests++;
            assert ($onehot0({AluEn, MemRead, MemWrite, RegWrite})) else begin
                fails++;
                $error("FAIL strobe_onehot: observed %b expected at most one high",
                       {AluEn, MemRead, MemWrite, RegWrite});
            end
        end
    end

    // Waits for the request, optionally stalls the ack with Run low, then acks; returns in DECODE.
    task automatic do_fetch(input logic [7:0] addr, input logic [9:0] data, input int delay);
        int waited = 0;
        while (InstrReq !== 1'b1 && waited < 20) begin
            tick();
            waited++;
        end
        check("fetch_req", 16'(InstrReq), 16'h1);
        check("fetch_addr", 16'(InstrAddr), 16'(addr));
        for (int i = 0; i < delay; i++) begin
            Run = 1'b0;
            tick();
            check("req_held", 16'(InstrReq), 16'h1);
        end
        InstrAck  = 1'b1;
        InstrData = data;
        tick();
        InstrAck  = 1'b0;
        InstrData = 10'h000;
        Run       = 1'b1;
        check("ir_load", 16'(Instruction), 16'(data));
        check("req_drop", 16'(InstrReq), 16'h0);
    endtask

    // BEQ/JUMP: fetch, decode, one EXEC cycle with Zero driven, then back in FETCH at exp_next.
    task automatic run_ctrl(input logic [7:0] addr, input logic [9:0] data, input logic z,
                            input logic [7:0] exp_next);
        do_fetch(addr, data, 0);
        tick();
        check("ctrl_exec_alu", 16'(AluEn), 16'h1);
        Zero = z;
        tick();
        Zero = 1'b0;
        check("ctrl_next_pc", 16'(InstrAddr), 16'(exp_next));
        check("ctrl_alu_off", 16'(AluEn), 16'h0);
    endtask

    initial begin
        #200000;
        $display("FAIL timeout: observed no finish expected finish");
        $fatal(1, "bench timeout");
    end

    initial begin
        ResetN = 1'b0; Run = 1'b0; InstrAck = 1'b0; InstrData = 10'h000;
        Zero = 1'b0; MemAck = 1'b0;
        repeat (2) tick();

        // Reset state
        check("rst_req", 16'(InstrReq), 16'h0);
        check("rst_pc", 16'(InstrAddr), 16'h0);
        check("rst_ir", 16'(Instruction), 16'h0);
        check("rst_strobes", 16'({AluEn, MemRead, MemWrite, RegWrite}), 16'h0);
        check("rst_wbsel", 16'(WbSel), 16'h0);
        check("rst_flags", 16'({Halted, Illegal}), 16'h0);
`ifdef INSTR_SEQ_RETIRE_CNT_EN
        check("rst_retired", RetiredCount, 16'h0);
`endif

        // ALU op 1 with immediate ack
        ResetN = 1'b1; Run = 1'b1;
        tick();
        check("first_req", 16'(InstrReq), 16'h1);
        do_fetch(8'h00, 10'h045, 0);
        check("alu_decode_quiet", 16'({AluEn, RegWrite}), 16'h0);
        tick();
        check("alu_exec", 16'(AluEn), 16'h1);
        check("alu_exec_wbsel", 16'(WbSel), 16'h0);
        tick();
        check("alu_wb_regwrite", 16'(RegWrite), 16'h1);
        check("alu_wb_wbsel", 16'(WbSel), 16'h0);
        tick();
        check("alu_next_req", 16'(InstrReq), 16'h1);
        check("alu_next_pc", 16'(InstrAddr), 16'h1);

        // LOAD with MemAck delayed 3 cycles
        do_fetch(8'h01, 10'h203, 0);
        tick();
        check("load_exec_wbsel", 16'(WbSel), 16'h1);
        tick();
        for (int k = 0; k < 4; k++) begin
            check("load_memread", 16'(MemRead), 16'h1);
            check("load_no_memwrite", 16'(MemWrite), 16'h0);
            if (k == 3) MemAck = 1'b1;
            tick();
        end
        MemAck = 1'b0;
        check("load_memread_off", 16'(MemRead), 16'h0);
        check("load_wb_regwrite", 16'(RegWrite), 16'h1);
        check("load_wb_wbsel", 16'(WbSel), 16'h1);
        tick();
        check("load_next_pc", 16'(InstrAddr), 16'h2);
        check("load_wbsel_idle", 16'(WbSel), 16'h0);

        // JUMP with delayed ack and Run falling mid-request, then BEQ cases and PC wrap
        do_fetch(8'h02, 10'h2C5, 2);
        tick();
        check("jump_exec", 16'(AluEn), 16'h1);
        tick();
        check("jump_target", 16'(InstrAddr), 16'h05);
        Zero = 1'b0;
        run_ctrl(8'h05, 10'h2BE, 1'b1, 8'h03);
        run_ctrl(8'h03, 10'h2C5, 1'b0, 8'h05);
        run_ctrl(8'h05, 10'h2BE, 1'b0, 8'h06);
        run_ctrl(8'h06, 10'h2C1, 1'b0, 8'h01);
        run_ctrl(8'h01, 10'h2BC, 1'b1, 8'hFD);
        do_fetch(8'hFD, 10'h340, 0);
        tick();
        check("nop_pc_fe", 16'(InstrAddr), 16'hFE);
        do_fetch(8'hFE, 10'h340, 0);
        tick();
        check("nop_pc_ff", 16'(InstrAddr), 16'hFF);
        do_fetch(8'hFF, 10'h340, 0);
        tick();
        check("nop_pc_wrap", 16'(InstrAddr), 16'h00);

        // Illegal opcode halts sticky until reset
        do_fetch(8'h00, 10'h380, 0);
        check("illegal_decode_flags", 16'({Halted, Illegal}), 16'h0);
        tick();
        check("illegal_halt_flags", 16'({Halted, Illegal}), 16'h3);
        for (int i = 0; i < 4; i++) begin
            Run = i[0];
            tick();
            check("halt_hold_flags", 16'({Halted, Illegal}), 16'h3);
            check("halt_no_req", 16'(InstrReq), 16'h0);
        end
        ResetN = 1'b0;
        tick();
        check("halt_reset_flags", 16'({Halted, Illegal}), 16'h0);
        ResetN = 1'b1; Run = 1'b1;

        // Reset while MemRead pending; late MemAck ignored
        do_fetch(8'h00, 10'h203, 0);
        tick();
        tick();
        check("rst_mid_memread", 16'(MemRead), 16'h1);
        ResetN = 1'b0;
        tick();
        check("rst_mid_memread_off", 16'(MemRead), 16'h0);
        check("rst_mid_pc", 16'(InstrAddr), 16'h0);
        check("rst_mid_ir", 16'(Instruction), 16'h0);
        ResetN = 1'b1; Run = 1'b0; MemAck = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            check("late_ack_no_regwrite", 16'(RegWrite), 16'h0);
            check("late_ack_no_memread", 16'(MemRead), 16'h0);
            check("run_low_no_req", 16'(InstrReq), 16'h0);
        end
        MemAck = 1'b0;

        // NOP, ALU, STORE, HALT
        Run = 1'b1;
        do_fetch(8'h00, 10'h340, 0);
        tick();
        check("seq_nop_pc", 16'(InstrAddr), 16'h1);
        do_fetch(8'h01, 10'h045, 0);
        repeat (3) tick();
        check("seq_alu_pc", 16'(InstrAddr), 16'h2);
        do_fetch(8'h02, 10'h240, 0);
        tick();
        check("store_exec", 16'(AluEn), 16'h1);
        tick();
        check("store_memwrite", 16'(MemWrite), 16'h1);
        check("store_no_memread", 16'(MemRead), 16'h0);
        MemAck = 1'b1;
        tick();
        MemAck = 1'b0;
        check("store_memwrite_off", 16'(MemWrite), 16'h0);
        check("store_no_regwrite", 16'(RegWrite), 16'h0);
        check("store_next_pc", 16'(InstrAddr), 16'h3);
        do_fetch(8'h03, 10'h3C0, 0);
        tick();
        check("halt_op_flags", 16'({Halted, Illegal}), 16'h2);
`ifdef INSTR_SEQ_RETIRE_CNT_EN
        check("retired_count", RetiredCount, 16'h3);
`endif
        repeat (3) tick();
        check("halt_op_hold", 16'(Halted), 16'h1);
        check("halt_op_no_req", 16'(InstrReq), 16'h0);
`ifdef INSTR_SEQ_RETIRE_CNT_EN
        check("retired_count_hold", RetiredCount, 16'h3);
`endif

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
